// File: rtl/arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells: FSM state encoding
// and the width of the per-operation bit counter.
package arith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with the borrow into the next bit.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// A start/done handshake is used; the result holds until the next accepted start.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow_out
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow;
  logic             d_bit, c_nxt;
  logic             accept, last;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (borrow),
    .diff (d_bit),
    .bout (c_nxt)
  );

  assign ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign accept = ready && start;
  assign last   = (state_q == ST_SHIFT) && (cnt == LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt == LAST) state_d = ST_DONE;
      ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand capture on accept, one bit consumed per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= minuend;
      b_sr   <= subtrahend;
      borrow <= 1'b0;
      cnt    <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      borrow <= c_nxt;
      cnt    <= cnt + 1'b1;
    end
  end

  // Visible result only moves on the final bit, so it stays stable mid-operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      difference <= '0;
      borrow_out <= 1'b0;
    end else if (last) begin
      difference <= {d_bit, res_sr[WIDTH-1:1]};
      borrow_out <= c_nxt;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: vector table at WIDTH=8, handshake corner
// sequences, and an exhaustive sweep of a WIDTH=4 instance.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] minuend, subtrahend;
  logic       ready, done, borrow_out;
  logic [7:0] difference;

  logic       start4;
  logic [3:0] a4, b4;
  logic       ready4, done4, bo4;
  logic [3:0] d4;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .minuend(minuend), .subtrahend(subtrahend),
    .ready(ready), .done(done), .difference(difference), .borrow_out(borrow_out)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .minuend(a4), .subtrahend(b4),
    .ready(ready4), .done(done4), .difference(d4), .borrow_out(bo4)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bo;
  } vec_t;

  vec_t vt[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // One op on the 8-bit instance; lat = edges after the accepting edge until done.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
    minuend = a; subtrahend = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, pulses, bad_rdy;
    logic [4:0] e4;

    vt[0] = '{8'd5,   8'd3,   8'd2,   1'b0};
    vt[1] = '{8'd3,   8'd5,   8'd254, 1'b1};
    vt[2] = '{8'h00,  8'h01,  8'hFF,  1'b1};
    vt[3] = '{8'hFF,  8'hFF,  8'h00,  1'b0};
    vt[4] = '{8'h00,  8'h00,  8'h00,  1'b0};
    vt[5] = '{8'h80,  8'h01,  8'h7F,  1'b0};
    vt[6] = '{8'h01,  8'h80,  8'h81,  1'b1};
    vt[7] = '{8'hAA,  8'h55,  8'h55,  1'b0};
    vt[8] = '{8'h00,  8'hFF,  8'h01,  1'b1};
    vt[9] = '{8'h7F,  8'h80,  8'hFF,  1'b1};

    rst = 1'b1; start = 1'b0; minuend = '0; subtrahend = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    #12;
    chk("reset_ready", ready, 1);
    chk("reset_done", done, 0);
    chk("reset_diff", difference, 0);
    chk("reset_borrow", borrow_out, 0);
    #5 rst = 1'b0;
    tick();

    // Table vectors
    for (int i = 0; i < 10; i++) begin
      run8(vt[i].a, vt[i].b, lat);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_diff", i), difference, vt[i].diff);
      chk($sformatf("vec%0d_borrow", i), borrow_out, vt[i].bo);
      tick();
    end

    // Result holds while idle with operands wandering
    minuend = 8'h33; subtrahend = 8'h11;
    tick(); tick(); tick();
    chk("hold_diff", difference, 8'hFF);
    chk("hold_idle_done", done, 0);

    // start re-pulsed through SHIFT with other operands is ignored
    pulses = 0; bad_rdy = 0;
    minuend = 8'd5; subtrahend = 8'd3; start = 1'b1;
    tick();
    for (int i = 0; i < 7; i++) begin
      minuend = 8'(i * 37 + 11); subtrahend = 8'(i * 19 + 200);
      start = 1'b1;
      tick();
      if (done) pulses++;
      if (ready) bad_rdy++;
    end
    start = 1'b0;
    tick();
    if (done) pulses++;
    chk("repulse_diff", difference, 8'd2);
    chk("repulse_borrow", borrow_out, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("repulse_pulses", pulses, 1);
    chk("repulse_ready_in_shift", bad_rdy, 0);

    // Back-to-back with start held high
    bad_rdy = 0;
    minuend = 8'd10; subtrahend = 8'd4; start = 1'b1;
    tick();
    minuend = 8'd4; subtrahend = 8'd10;
    lat = 0;
    while (!done && lat < 40) begin
      if (ready !== done) bad_rdy++;
      tick();
      lat++;
    end
    chk("b2b_first_latency", lat, 8);
    chk("b2b_first_diff", difference, 8'd6);
    chk("b2b_first_borrow", borrow_out, 0);
    chk("b2b_first_ready", ready, 1);
    tick();
    lat = 1;
    while (!done && lat < 40) begin
      if (ready !== done) bad_rdy++;
      tick();
      lat++;
    end
    chk("b2b_spacing", lat, 9);
    chk("b2b_second_diff", difference, 8'd250);
    chk("b2b_second_borrow", borrow_out, 1);
    chk("b2b_ready_only_done", bad_rdy, 0);
    start = 1'b0;
    tick();

    // Async reset mid-SHIFT at count==3
    minuend = 8'd5; subtrahend = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("midrst_diff", difference, 0);
    chk("midrst_borrow", borrow_out, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", ready, 1);
    #2 rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) pulses++;
    end
    chk("midrst_no_done", pulses, 0);
    run8(8'd100, 8'd1, lat);
    chk("after_rst_latency", lat, 8);
    chk("after_rst_diff", difference, 8'd99);
    chk("after_rst_borrow", borrow_out, 0);
    tick();

    // Exhaustive WIDTH=4 sweep
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        a4 = 4'(ia); b4 = 4'(ib); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        lat = 0;
        while (!done4 && lat < 20) begin
          tick();
          lat++;
        end
        e4 = {1'b0, 4'(ia)} - {1'b0, 4'(ib)};
        chk($sformatf("w4_%0d_%0d", ia, ib), {lat[7:0], 3'b0, bo4, d4}, {8'd4, 3'b0, e4});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
